// File: rtl/wb_sel_sequencer_pkg.sv
// Shared write-back path definitions: mux selects, requester indices, FSM states.
package wb_sel_sequencer_pkg;

    localparam int unsigned NUM_REQ  = 3;

    localparam int unsigned REQ_ALU  = 0;
    localparam int unsigned REQ_LOAD = 1;
    localparam int unsigned REQ_SWAP = 2;

    localparam logic [1:0] SEL_ALU  = 2'd0;
    localparam logic [1:0] SEL_LOAD = 2'd1;
    localparam logic [1:0] SEL_SWAP = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SWAP  = 2'd2
    } state_e;

endpackage

// File: rtl/wb_sel_sequencer_if.sv
// Request/grant and write-address mux control bundle of the write-back sequencer.
interface wb_sel_sequencer_if
    import wb_sel_sequencer_pkg::*;
#(
    parameter int unsigned SEL_W = 2
);
    logic                 stall;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   gnt;
    logic [SEL_W-1:0]     mux_sel;
    logic                 rf_we;
    logic                 swap_phase;
    logic                 busy;
    logic                 starve;

    // Pipeline / requester side.
    modport master (
        output stall, req,
        input  gnt, mux_sel, rf_we, swap_phase, busy, starve
    );

    // Sequencer side.
    modport slave (
        input  stall, req,
        output gnt, mux_sel, rf_we, swap_phase, busy, starve
    );
endinterface

// File: rtl/wb_sel_sequencer_arb_pick.sv
// wb_arb_pick: combinational winner select among the three write-port requesters.
// Round-robin variant is built when WB_ROUND_ROBIN_EN is defined, fixed priority otherwise.
module wb_arb_pick
    import wb_sel_sequencer_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
`ifdef WB_ROUND_ROBIN_EN
    input  logic [1:0]         ptr,
`endif
    output logic               win_valid_c,
    output logic [1:0]         win_idx_c
);

`ifdef WB_ROUND_ROBIN_EN
    logic [1:0] cand;

    // Search ptr+1, ptr+2, ptr (mod 3); loop runs backwards so the nearest candidate wins.
    always_comb begin
        win_valid_c = 1'b0;
        win_idx_c   = 2'd0;
        cand        = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            cand = 2'((int'(ptr) + k) % 3);
            if (req[cand]) begin
                win_valid_c = 1'b1;
                win_idx_c   = cand;
            end
        end
    end
`else
    // Fixed priority: swap > load > ALU.
    always_comb begin
        win_valid_c = 1'b0;
        win_idx_c   = 2'd0;
        if (req[REQ_SWAP]) begin
            win_valid_c = 1'b1;
            win_idx_c   = 2'(REQ_SWAP);
        end else if (req[REQ_LOAD]) begin
            win_valid_c = 1'b1;
            win_idx_c   = 2'(REQ_LOAD);
        end else if (req[REQ_ALU]) begin
            win_valid_c = 1'b1;
            win_idx_c   = 2'(REQ_ALU);
        end
    end
`endif

endmodule

// File: rtl/wb_sel_sequencer.sv
// Write-back port sequencer: arbitrates ALU/load/swap onto the single rf write port
// and sequences SWAP as SWAP_BEATS back-to-back beats. Optional macro WB_ROUND_ROBIN_EN
// selects round-robin arbitration instead of fixed priority.
module wb_sel_sequencer
    import wb_sel_sequencer_pkg::*;
#(
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned SWAP_BEATS = 2,
    parameter int unsigned MAX_WAIT   = 15
) (
    input  logic               clk,
    input  logic               rst_f,
    wb_sel_sequencer_if.slave  bus
);

    localparam int unsigned BEAT_W = (SWAP_BEATS > 1) ? $clog2(SWAP_BEATS) : 1;
    localparam int unsigned WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(SWAP_BEATS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(MAX_WAIT);

    state_e               state_q, state_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 we_q, we_d;
    logic                 phase_q, phase_d;
    logic                 busy_q, busy_d;
    logic                 starve_q, starve_d;
    logic                 swap_more;
    logic                 win_valid_c;
    logic [1:0]           win_idx_c;

`ifdef WB_ROUND_ROBIN_EN
    logic [1:0]           ptr_q, ptr_d;

    wb_arb_pick u_pick (
        .req         (bus.req),
        .ptr         (ptr_q),
        .win_valid_c (win_valid_c),
        .win_idx_c   (win_idx_c)
    );
`else
    wb_arb_pick u_pick (
        .req         (bus.req),
        .win_valid_c (win_valid_c),
        .win_idx_c   (win_idx_c)
    );
`endif

    // State, counters and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            wait_q   <= '0;
            gnt_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            phase_q  <= 1'b0;
            busy_q   <= 1'b0;
            starve_q <= 1'b0;
`ifdef WB_ROUND_ROBIN_EN
            ptr_q    <= 2'(REQ_SWAP);
`endif
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            wait_q   <= wait_d;
            gnt_q    <= gnt_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            phase_q  <= phase_d;
            busy_q   <= busy_d;
            starve_q <= starve_d;
`ifdef WB_ROUND_ROBIN_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    // A stalled edge withholds the beat it would have issued; that beat goes out on the
    // first unstalled edge, so SWAP beats are never lost or doubled.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        gnt_d     = '0;
        sel_d     = sel_q;
        we_d      = 1'b0;
        phase_d   = 1'b0;
        busy_d    = 1'b0;
        wait_d    = wait_q;
`ifdef WB_ROUND_ROBIN_EN
        ptr_d     = ptr_q;
`endif
        swap_more = (state_q == ST_SWAP) && (beat_q != LAST_BEAT);

        if (bus.stall) begin
            phase_d = phase_q;
            busy_d  = swap_more;
        end else if (swap_more) begin
            beat_d          = beat_q + BEAT_W'(1);
            gnt_d[REQ_SWAP] = 1'b1;
            sel_d           = SEL_W'(SEL_SWAP);
            we_d            = 1'b1;
            phase_d         = 1'b1;
            busy_d          = 1'b1;
        end else if (win_valid_c) begin
            gnt_d[win_idx_c] = 1'b1;
            sel_d            = SEL_W'(win_idx_c);
            we_d             = 1'b1;
`ifdef WB_ROUND_ROBIN_EN
            // Pointer is only consulted at the next arbitration, which cannot happen
            // before this grant's final beat, so it is loaded with the winner now.
            ptr_d            = win_idx_c;
`endif
            if (win_idx_c == 2'(REQ_SWAP)) begin
                state_d = ST_SWAP;
                beat_d  = '0;
                busy_d  = 1'b1;
            end else begin
                state_d = ST_GRANT;
            end
        end else begin
            state_d = ST_IDLE;
        end

        // ALU starvation counter: saturating, cleared on an ALU grant.
        if (gnt_d[REQ_ALU]) begin
            wait_d = '0;
        end else if (bus.req[REQ_ALU] && (wait_q != WAIT_LIM)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
        starve_d = starve_q | ((MAX_WAIT != 0) && (wait_d == WAIT_LIM));
    end

    assign bus.gnt        = gnt_q;
    assign bus.mux_sel    = sel_q;
    assign bus.rf_we      = we_q;
    assign bus.swap_phase = phase_q;
    assign bus.busy       = busy_q;
    assign bus.starve     = starve_q;

endmodule

// File: tb/tb_wb_sel_sequencer.sv
// Scoreboard bench for wb_sel_sequencer: driver pushes expected outputs from a
// beat-level reference model, negedge monitor pops and compares.
module tb_wb_sel_sequencer;

    localparam int SWAP_BEATS = 2;
    localparam int MAX_WAIT   = 15;

    typedef struct packed {
        logic [2:0] gnt;
        logic [1:0] sel;
        logic       we;
        logic       phase;
        logic       busy;
        logic       starve;
    } obs_t;

    logic clk;
    logic rst_f;

    wb_sel_sequencer_if #(.SEL_W(2)) bus ();

    wb_sel_sequencer #(
        .SEL_W      (2),
        .SWAP_BEATS (SWAP_BEATS),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: beats still owed to an open SWAP, last select, ALU wait, pointer.
    int   m_swap_left;
    int   m_sel;
    bit   m_phase;
    int   m_wait;
    bit   m_starve;
    int   m_ptr;

    task automatic model_step(input logic r, input logic s, input logic [2:0] q);
        obs_t e;
        int   win;
        e = '0;
        if (!r) begin
            m_swap_left = 0;
            m_sel       = 0;
            m_phase     = 0;
            m_wait      = 0;
            m_starve    = 0;
            m_ptr       = 2;
        end else begin
            if (s) begin
                e.busy = (m_swap_left > 0);
            end else if (m_swap_left > 0) begin
                m_swap_left = m_swap_left - 1;
                e.gnt  = 3'b100;
                m_sel  = 2;
                e.we   = 1'b1;
                m_phase = 1;
                e.busy = 1'b1;
            end else if (q != 3'b000) begin
                win = -1;
`ifdef WB_ROUND_ROBIN_EN
                for (int k = 1; k <= 3; k++) begin
                    if (win < 0 && q[(m_ptr + k) % 3]) win = (m_ptr + k) % 3;
                end
                m_ptr = win;
`else
                for (int k = 0; k < 3; k++) begin
                    if (q[k]) win = k;
                end
`endif
                e.gnt[win] = 1'b1;
                m_sel      = win;
                e.we       = 1'b1;
                m_phase    = 0;
                if (win == 2) begin
                    m_swap_left = SWAP_BEATS - 1;
                    e.busy      = 1'b1;
                end
            end else begin
                m_phase = 0;
            end
            if (!s && m_swap_left == 0 && e.gnt[0]) m_phase = 0;
            if (e.gnt[0]) m_wait = 0;
            else if (q[0] && m_wait < MAX_WAIT) m_wait = m_wait + 1;
            if (MAX_WAIT > 0 && m_wait >= MAX_WAIT) m_starve = 1;
        end
        e.sel    = 2'(m_sel);
        e.phase  = m_phase;
        e.starve = m_starve;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs just after the falling edge and record what must follow.
    task automatic drive(input logic r, input logic s, input logic [2:0] q);
        @(negedge clk);
        #1;
        rst_f     = r;
        bus.stall = s;
        bus.req   = q;
        model_step(r, s, q);
    endtask

    // Directed point check of a single observed value.
    task automatic check_val(input string what, input logic [3:0] got, input logic [3:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s t=%0t got=%b required=%b", what, $time, got, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare them at the falling edge.
    always @(negedge clk) begin
        obs_t e;
        obs_t g;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            g.gnt    = bus.gnt;
            g.sel    = bus.mux_sel;
            g.we     = bus.rf_we;
            g.phase  = bus.swap_phase;
            g.busy   = bus.busy;
            g.starve = bus.starve;
            checks = checks + 1;
            if (g !== e) begin
                failures = failures + 1;
                $display("FAIL outputs t=%0t got gnt=%b sel=%0d we=%b ph=%b busy=%b starve=%b required gnt=%b sel=%0d we=%b ph=%b busy=%b starve=%b",
                         $time, g.gnt, g.sel, g.we, g.phase, g.busy, g.starve,
                         e.gnt, e.sel, e.we, e.phase, e.busy, e.starve);
            end
        end
    end

    initial begin
        rst_f     = 1'b0;
        bus.stall = 1'b0;
        bus.req   = 3'b000;

        // Reset held with all requests asserted.
        repeat (3) drive(1'b0, 1'b0, 3'b111);
        check_val("reset gnt", {1'b0, bus.gnt}, 4'd0);
        check_val("reset rf_we", {3'b000, bus.rf_we}, 4'd0);
        check_val("reset mux_sel", {2'b00, bus.mux_sel}, 4'd0);
        drive(1'b1, 1'b0, 3'b000);

        // Single ALU write, then idle.
        drive(1'b1, 1'b0, 3'b001);
        repeat (2) drive(1'b1, 1'b0, 3'b000);

        // Single load and a single SWAP sequence.
        drive(1'b1, 1'b0, 3'b010);
        drive(1'b1, 1'b0, 3'b100);
        repeat (3) drive(1'b1, 1'b0, 3'b000);

        // ALU/load contention held long enough to reach the starvation limit.
        repeat (20) drive(1'b1, 1'b0, 3'b011);
`ifdef WB_ROUND_ROBIN_EN
        check_val("starve after contention", {3'b000, bus.starve}, 4'd0);
`else
        check_val("starve after contention", {3'b000, bus.starve}, 4'd1);
`endif
        drive(1'b1, 1'b0, 3'b000);

        // SWAP with a 3-cycle stall in place of its second beat.
        drive(1'b0, 1'b0, 3'b000);
        drive(1'b1, 1'b0, 3'b100);
        repeat (3) drive(1'b1, 1'b1, 3'b000);
        repeat (3) drive(1'b1, 1'b0, 3'b000);

        // Reset landing on the first SWAP beat.
        drive(1'b1, 1'b0, 3'b100);
        drive(1'b0, 1'b0, 3'b000);
        repeat (3) drive(1'b1, 1'b0, 3'b000);

        // Swap competing with others, then randomized traffic.
        repeat (6) drive(1'b1, 1'b0, 3'b111);
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 79) != 0),
                  ($urandom_range(0, 7) == 0),
                  3'($urandom_range(0, 7)));
        end
        drive(1'b1, 1'b0, 3'b000);

        repeat (3) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
